toycpu_multicycle: RTL and testbench

TOYCPU_MULTICYCLE -- requirements
Module: toycpu_multicycle

---
 rtl/toycpu_multicycle.sv | 176 +++++++++++++++++
 tb/tb_toycpu_multicycle.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/toycpu_multicycle.sv
// Multicycle toy CPU: FETCH/EXEC/HALT FSM, small register file,
// 8-opcode ALU with carry/zero flags and relative branches.
module toycpu_multicycle #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 4,
  parameter int PC_W   = 16,
  localparam int RW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_data,
  output logic [PC_W-1:0]   pc,
  output logic [15:0]       instr,
  output logic              c_flag,
  output logic              z_flag,
  output logic              halted,
  output logic [15:0]       retired,
  input  logic [RW-1:0]     dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [1:0] {
    FETCH,
    EXEC,
    HALT
  } state_e;

  state_e state_q, state_d;

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [15:0]       instr_q, instr_d;
  logic [15:0]       ret_q, ret_d;
  logic              c_q, c_d;
  logic              z_q, z_d;
  logic [DATA_W-1:0] rf_q [NREGS];

  logic              rf_we;
  logic [RW-1:0]     rf_wa;
  logic [DATA_W-1:0] rf_wd;

  logic [2:0]        op;
  logic [RW-1:0]     rd, rs1, rs2;
  logic [7:0]        imm;
  logic [DATA_W-1:0] a, b, and_r;
  logic [DATA_W:0]   sum, diff;
  logic [PC_W-1:0]   pc_inc, pc_br;
  logic              flag, taken;
  logic              unused_bits;

  assign op  = instr_q[15:13];
  assign rd  = instr_q[10 +: RW];
  assign rs1 = instr_q[7 +: RW];
  assign rs2 = instr_q[4 +: RW];
  assign imm = instr_q[7:0];

  assign unused_bits = ^instr_q;

  // Operands come from the current register state, so rd may alias a source.
  assign a     = rf_q[rs1];
  assign b     = rf_q[rs2];
  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  assign and_r = a & b;

  assign pc_inc = pc_q + PC_W'(1);
  assign pc_br  = pc_inc + PC_W'($signed(imm));
  assign flag   = instr_q[12] ? z_q : c_q;
  assign taken  = instr_q[10] | (flag == instr_q[11]);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    ret_d    = ret_q;
    c_d      = c_q;
    z_d      = z_q;
    imem_req = 1'b0;
    rf_we    = 1'b0;
    rf_wa    = rd;
    rf_wd    = a;
    unique case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_d = imem_data;
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = FETCH;
        pc_d    = pc_inc;
        if (ret_q != 16'hFFFF) begin
          ret_d = ret_q + 16'd1;
        end
        unique case (op)
          3'b000: begin
            rf_we = 1'b1;
            rf_wd = DATA_W'(imm);
          end
          3'b001: begin
            rf_we = 1'b1;
            rf_wd = sum[DATA_W-1:0];
            c_d   = sum[DATA_W];
            z_d   = (sum[DATA_W-1:0] == '0);
          end
          3'b010: begin
            rf_we = 1'b1;
            rf_wd = diff[DATA_W-1:0];
            c_d   = diff[DATA_W];
            z_d   = (diff[DATA_W-1:0] == '0);
          end
          3'b011: begin
            rf_we = 1'b1;
            rf_wd = and_r;
            z_d   = (and_r == '0);
          end
          3'b100: begin
            rf_we = 1'b1;
            rf_wd = a;
          end
          3'b101: begin
            if (taken) begin
              pc_d = pc_br;
            end
          end
          3'b110: begin
          end
          3'b111: begin
            pc_d    = pc_q;
            state_d = HALT;
          end
        endcase
      end
      HALT: begin
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= '0;
      instr_q <= '0;
      ret_q   <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ret_q   <= ret_d;
      c_q     <= c_d;
      z_q     <= z_d;
      if (rf_we) begin
        rf_q[rf_wa] <= rf_wd;
      end
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign c_flag    = c_q;
  assign z_flag    = z_q;
  assign halted    = (state_q == HALT);
  assign retired   = ret_q;
  assign dbg_data  = rf_q[dbg_sel];

endmodule

// File: tb/tb_toycpu_multicycle.sv
// Scoreboard bench for toycpu_multicycle: random and directed programs
// checked against an architectural model of the instruction set.
`timescale 1ns/1ps
module tb_toycpu_multicycle;
  localparam int DATA_W = 16;
  localparam int NREGS  = 4;
  localparam int PC_W   = 16;
  localparam int RW     = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_ack = 1'b0;
  logic [15:0]       imem_data = '0;
  logic [PC_W-1:0]   pc;
  logic [15:0]       instr;
  logic              c_flag, z_flag, halted;
  logic [15:0]       retired;
  logic [RW-1:0]     dbg_sel;
  logic [DATA_W-1:0] dbg_data;

  logic [RW-1:0] mon_sel = '0;
  logic [RW-1:0] main_sel = '0;
  logic          mon_busy = 1'b0;
  assign dbg_sel = mon_busy ? mon_sel : main_sel;

  always #10 clk = ~clk;

  toycpu_multicycle #(
    .DATA_W(DATA_W), .NREGS(NREGS), .PC_W(PC_W)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .pc(pc), .instr(instr),
    .c_flag(c_flag), .z_flag(z_flag),
    .halted(halted), .retired(retired),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  typedef struct packed {
    logic [PC_W-1:0]              pc;
    logic [NREGS-1:0][DATA_W-1:0] regs;
    logic                         c;
    logic                         z;
    logic                         h;
    logic [15:0]                  ret;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] prog[int];

  logic [NREGS-1:0][DATA_W-1:0] m_regs;
  longint m_pc, m_ret;
  bit     m_c, m_z, m_h;
  int     m_issued;
  int     n_cmp = 0;
  int     n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)",
               nm, act, expv, $time);
    end
  endtask

  function automatic logic [15:0] enc_r(int op, int rd, int s1, int s2);
    return {3'(op), 3'(rd), 3'(s1), 3'(s2), 4'b0};
  endfunction

  function automatic logic [15:0] enc_i(int op, int rd, int im);
    return {3'(op), 3'(rd), 2'b00, 8'(im)};
  endfunction

  function automatic logic [15:0] enc_br(int sel, int val, int unc, int im);
    return {3'b101, 1'(sel), 1'(val), 1'(unc), 2'b00, 8'(im)};
  endfunction

  function automatic logic [15:0] rand_instr();
    int p;
    logic [15:0] w;
    p = int'($urandom_range(0, 99));
    w = 16'($urandom);
    if (p < 4)       return {3'b111, w[12:0]};
    else if (p < 20) return {3'b000, w[12:0]};
    else if (p < 36) return {3'b001, w[12:0]};
    else if (p < 52) return {3'b010, w[12:0]};
    else if (p < 62) return {3'b011, w[12:0]};
    else if (p < 72) return {3'b100, w[12:0]};
    else if (p < 86) return {3'b101, w[12:0]};
    else             return {3'b110, w[12:0]};
  endfunction

  task automatic model_reset();
    m_regs   = '0;
    m_pc     = 0;
    m_ret    = 0;
    m_c      = 0;
    m_z      = 0;
    m_h      = 0;
    m_issued = 0;
  endtask

  // Instruction semantics computed with plain integer arithmetic.
  task automatic model_exec(input logic [15:0] ins);
    longint dm, pm, a, b, r, off, npc;
    int op, rd, s1, s2;
    bit f;
    dm  = longint'(1) << DATA_W;
    pm  = longint'(1) << PC_W;
    op  = int'(ins[15:13]);
    rd  = int'(ins[12:10]) % NREGS;
    s1  = int'(ins[9:7]) % NREGS;
    s2  = int'(ins[6:4]) % NREGS;
    a   = longint'(m_regs[s1]);
    b   = longint'(m_regs[s2]);
    npc = (m_pc + 1) % pm;
    case (op)
      0: m_regs[rd] = DATA_W'(ins[7:0]);
      1: begin
        r = a + b;
        m_c = (r >= dm);
        r = r % dm;
        m_z = (r == 0);
        m_regs[rd] = DATA_W'(r);
      end
      2: begin
        r = (a - b + dm) % dm;
        m_c = (a < b);
        m_z = (r == 0);
        m_regs[rd] = DATA_W'(r);
      end
      3: begin
        r = a & b;
        m_z = (r == 0);
        m_regs[rd] = DATA_W'(r);
      end
      4: m_regs[rd] = DATA_W'(a);
      5: begin
        f = ins[12] ? m_z : m_c;
        off = longint'(ins[7:0]);
        if (off >= 128) off = off - 256;
        if (ins[10] || (f == ins[11]))
          npc = (m_pc + 1 + off + pm) % pm;
      end
      7: begin
        npc = m_pc;
        m_h = 1;
      end
      default: ;
    endcase
    m_pc = npc;
    if (m_ret < 65535) m_ret = m_ret + 1;
    m_issued++;
    exp_q.push_back('{pc: PC_W'(m_pc), regs: m_regs, c: m_c,
                      z: m_z, h: m_h, ret: 16'(m_ret)});
  endtask

  // One clock of stimulus; inputs change 2ns after the rising edge.
  task automatic tick(input bit r, input int stall);
    @(posedge clk);
    #2;
    rst = r;
    imem_ack = 1'b0;
    imem_data = 16'($urandom);
    if (r) begin
      model_reset();
      exp_q.delete();
    end else if (imem_req === 1'b1 && !m_h) begin
      if (int'($urandom_range(0, 99)) >= stall) begin
        if (!prog.exists(int'(m_pc))) prog[int'(m_pc)] = rand_instr();
        imem_ack  = 1'b1;
        imem_data = prog[int'(m_pc)];
        model_exec(imem_data);
      end
    end
  endtask

  task automatic run_instrs(input int n, input int stall, input bit drain);
    int target, cyc;
    target = m_issued + n;
    cyc = 0;
    while (m_issued < target && !m_h && cyc < 60 * n + 100) begin
      tick(1'b0, stall);
      cyc++;
    end
    if (m_issued < target && !m_h) begin
      n_cmp++;
      n_err++;
      $display("FAIL run_timeout: got %0d instrs, expected %0d",
               m_issued, target);
    end
    if (drain) tick(1'b0, 100);
  endtask

  task automatic main_rd(input int i, output logic [DATA_W-1:0] v);
    main_sel = RW'(i);
    #1;
    v = dbg_data;
  endtask

  task automatic check_reset(input string nm);
    logic [DATA_W-1:0] v;
    chk({nm, "_pc"}, pc, 0);
    chk({nm, "_addr"}, imem_addr, 0);
    chk({nm, "_halted"}, halted, 0);
    chk({nm, "_retired"}, retired, 0);
    chk({nm, "_c"}, c_flag, 0);
    chk({nm, "_z"}, z_flag, 0);
    chk({nm, "_req"}, imem_req, 1);
    chk({nm, "_instr"}, instr, 0);
    for (int i = 0; i < NREGS; i++) begin
      main_rd(i, v);
      chk({nm, "_reg"}, v, 0);
    end
  endtask

  // Monitor: after every EXEC edge, pop and compare the architectural state.
  initial begin
    exp_t e;
    logic [DATA_W-1:0] v;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && imem_req === 1'b0 && halted === 1'b0) begin
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_retire: pc %0h, expected no retire", pc);
        end else begin
          e = exp_q.pop_front();
          chk("ret_pc", pc, e.pc);
          chk("ret_c", c_flag, e.c);
          chk("ret_z", z_flag, e.z);
          chk("ret_halted", halted, e.h);
          chk("ret_count", retired, e.ret);
          mon_busy = 1'b1;
          for (int i = 0; i < NREGS; i++) begin
            mon_sel = RW'(i);
            #1;
            v = dbg_data;
            chk("ret_reg", v, e.regs[i]);
          end
          mon_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [DATA_W-1:0] v;
    logic [PC_W-1:0] hpc;
    model_reset();

    prog.delete();
    tick(1'b1, 0);
    tick(1'b0, 100);
    @(negedge clk);
    check_reset("por");

    // ALU path, ack always granted
    prog.delete();
    prog[0] = enc_i(0, 0, 8'h0A);
    prog[1] = enc_i(0, 1, 8'h02);
    prog[2] = enc_r(1, 2, 0, 1);
    tick(1'b1, 0);
    run_instrs(3, 0, 1'b1);
    tick(1'b0, 100);
    @(negedge clk);
    chk("alu_pc", pc, 3);
    chk("alu_ret", retired, 3);
    main_rd(2, v);
    chk("alu_r2", v, 16'h000C);
    chk("alu_c", c_flag, 0);
    chk("alu_z", z_flag, 0);

    // Wrap-around and flags
    prog.delete();
    prog[0] = enc_i(0, 1, 0);
    prog[1] = enc_i(0, 2, 1);
    prog[2] = enc_r(2, 0, 1, 2);
    prog[3] = enc_r(1, 0, 0, 2);
    tick(1'b1, 0);
    run_instrs(3, 30, 1'b1);
    tick(1'b0, 100);
    @(negedge clk);
    main_rd(0, v);
    chk("sub_r0", v, 16'hFFFF);
    chk("sub_c", c_flag, 1);
    chk("sub_z", z_flag, 0);
    run_instrs(1, 30, 1'b1);
    tick(1'b0, 100);
    @(negedge clk);
    main_rd(0, v);
    chk("add_r0", v, 16'h0000);
    chk("add_c", c_flag, 1);
    chk("add_z", z_flag, 1);

    // Reset during a stalled fetch that is being acked
    tick(1'b0, 100);
    @(posedge clk);
    #2;
    rst = 1'b1;
    imem_ack = 1'b1;
    imem_data = enc_i(0, 3, 8'h55);
    model_reset();
    exp_q.delete();
    tick(1'b0, 100);
    @(negedge clk);
    check_reset("stallrst");

    // Branch back when taken, fall through when not
    prog.delete();
    prog[0] = enc_i(0, 1, 0);
    prog[1] = enc_i(0, 2, 1);
    prog[2] = enc_r(2, 0, 1, 1);
    prog[3] = enc_r(6, 0, 0, 0);
    prog[4] = enc_r(6, 0, 0, 0);
    prog[5] = enc_br(1, 1, 0, 8'hFD);
    tick(1'b1, 0);
    run_instrs(6, 20, 1'b1);
    tick(1'b0, 100);
    @(negedge clk);
    chk("br_taken_pc", pc, 3);
    prog[2] = enc_r(2, 0, 2, 1);
    tick(1'b1, 0);
    run_instrs(6, 20, 1'b1);
    tick(1'b0, 100);
    @(negedge clk);
    chk("br_nt_pc", pc, 6);

    // Branch wrapping around the top of the address space
    prog.delete();
    prog[0] = enc_r(2, 0, 0, 0);
    prog[1] = enc_br(0, 0, 1, 8'hFD);
    prog[16'hFFFF] = enc_br(1, 1, 0, 8'h7F);
    tick(1'b1, 0);
    run_instrs(2, 20, 1'b1);
    tick(1'b0, 100);
    @(negedge clk);
    chk("br_wrap_mid", pc, 16'hFFFF);
    run_instrs(1, 20, 1'b1);
    tick(1'b0, 100);
    @(negedge clk);
    chk("br_wrap_pc", pc, 16'h007F);

    // Fetch stall: nothing may move while ack is low
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 100);
      @(negedge clk);
      chk("stall_pc", pc, m_pc);
      chk("stall_ret", retired, m_ret);
      chk("stall_req", imem_req, 1);
      main_rd(0, v);
      chk("stall_r0", v, m_regs[0]);
    end
    prog[16'h007F] = enc_i(0, 1, 8'hA5);
    run_instrs(1, 0, 1'b1);

    // HALT freezes the machine until reset
    prog.delete();
    prog[0] = enc_i(0, 3, 8'h33);
    prog[1] = enc_r(7, 0, 0, 0);
    tick(1'b1, 0);
    run_instrs(5, 30, 1'b1);
    for (int k = 0; k < 10; k++) begin
      tick(1'b0, 0);
      @(negedge clk);
      chk("halt_flag", halted, 1);
      chk("halt_req", imem_req, 0);
      chk("halt_pc", pc, 1);
      chk("halt_ret", retired, 2);
    end
    tick(1'b1, 0);
    tick(1'b0, 100);
    @(negedge clk);
    check_reset("haltrst");

    // Random programs; reset lands in FETCH, EXEC or HALT
    for (int rnd = 0; rnd < 25; rnd++) begin
      prog.delete();
      tick(1'b1, 0);
      tick(1'b0, 100);
      @(negedge clk);
      check_reset("rnd_rst");
      run_instrs(int'($urandom_range(5, 80)), 30, 1'($urandom_range(0, 1)));
      if (m_h) begin
        hpc = PC_W'(m_pc);
        tick(1'b0, 0);
        tick(1'b0, 0);
        @(negedge clk);
        chk("rnd_halt", halted, 1);
        chk("rnd_halt_pc", pc, hpc);
      end
    end

    tick(1'b0, 100);
    tick(1'b0, 100);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
